// File: rtl/mfm_field_decoder.sv
// mfm_field_decoder
//   Byte-level MFM sector field decoder. Locks onto runs of three A1 sync
//   bytes, classifies the following address mark, parses ID fields (C/H/R/N)
//   and forwards data-field payload bytes, checking each field against an
//   embedded CRC-16 CCITT (poly 0x1021, init 0xFFFF, MSB first).
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   byte_valid      strobe qualifying byte_data / sync_mark
//   byte_data       assembled byte, MSB first
//   sync_mark       byte is an A1 with missing clock
//   abort           loss of lock / index, forces HUNT
//   id_valid        pulse: ID field complete; id_crc_ok/size_error valid
//   id_cyl/head/sector/size  latched C, H, R, N
//   data_valid/data_byte/data_last  payload byte stream
//   data_deleted    high for a whole F8 (deleted) data field
//   data_done       pulse after the data CRC bytes; data_crc_ok valid
//   orphan_dam      pulse: data mark with no accepted ID open
//   busy            decoder is not in HUNT
module mfm_field_decoder #(
    parameter int MAX_SIZE_CODE = 3,
    parameter int DAM_WINDOW    = 43
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       sync_mark,
    input  logic       abort,
    output logic       id_valid,
    output logic [7:0] id_cyl,
    output logic [7:0] id_head,
    output logic [7:0] id_sector,
    output logic [7:0] id_size,
    output logic       id_crc_ok,
    output logic       data_valid,
    output logic [7:0] data_byte,
    output logic       data_last,
    output logic       data_deleted,
    output logic       data_done,
    output logic       data_crc_ok,
    output logic       size_error,
    output logic       orphan_dam,
    output logic       busy
);

    localparam int         WIN_W     = $clog2(DAM_WINDOW + 1);
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_A1X3 = 16'hCDB4;
    localparam logic [7:0]  SYNC_BYTE = 8'hA1;
    localparam logic [7:0]  MARK_ID   = 8'hFE;
    localparam logic [7:0]  MARK_DATA = 8'hFB;
    localparam logic [7:0]  MARK_DEL  = 8'hF8;

    typedef enum logic [2:0] {HUNT, SYNC, ID, ID_CRC, DATA, DATA_CRC} state_t;

    state_t            state, ns;
    logic [15:0]       crc, crc_d;
    logic [1:0]        a_cnt, a_cnt_d;
    logic [1:0]        idx, idx_d;
    logic [10:0]       data_rem;
    logic [WIN_W-1:0]  win_cnt;
    logic              id_open;

    logic ev_fe, ev_dam, ev_orphan, ev_id_done, ev_data, ev_data_done, ev_drop;

    // One byte through the CCITT polynomial, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign busy = (state != HUNT);

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= ns;
    end

    always_comb begin
        ns           = state;
        crc_d        = crc;
        a_cnt_d      = a_cnt;
        idx_d        = idx;
        ev_fe        = 1'b0;
        ev_dam       = 1'b0;
        ev_orphan    = 1'b0;
        ev_id_done   = 1'b0;
        ev_data      = 1'b0;
        ev_data_done = 1'b0;
        ev_drop      = 1'b0;
        if (abort) begin
            ns      = HUNT;
            ev_drop = 1'b1;
        end else if (byte_valid) begin
            if (sync_mark) begin
                if (state == SYNC) begin
                    // Once three A1s are counted, further A1s restart the run so
                    // the CRC always covers exactly the last three.
                    if (a_cnt == 2'd3) begin
                        crc_d = CRC_A1X3;
                    end else begin
                        crc_d   = crc16_byte(crc, SYNC_BYTE);
                        a_cnt_d = a_cnt + 2'd1;
                    end
                end else begin
                    // A1 anywhere else starts a fresh sync run, abandoning any field.
                    crc_d   = crc16_byte(CRC_INIT, SYNC_BYTE);
                    a_cnt_d = 2'd1;
                    ns      = SYNC;
                    ev_drop = (state != HUNT);
                end
            end else begin
                case (state)
                    HUNT: ;
                    SYNC: begin
                        crc_d = crc16_byte(crc, byte_data);
                        idx_d = 2'd0;
                        ns    = HUNT;
                        if (a_cnt == 2'd3) begin
                            if (byte_data == MARK_ID) begin
                                ns    = ID;
                                ev_fe = 1'b1;
                            end else if (byte_data == MARK_DATA || byte_data == MARK_DEL) begin
                                if (id_open) begin
                                    ns     = DATA;
                                    ev_dam = 1'b1;
                                end else begin
                                    ev_orphan = 1'b1;
                                end
                            end
                        end
                    end
                    ID: begin
                        crc_d = crc16_byte(crc, byte_data);
                        idx_d = idx + 2'd1;
                        if (idx == 2'd3) begin
                            ns    = ID_CRC;
                            idx_d = 2'd0;
                        end
                    end
                    ID_CRC: begin
                        crc_d = crc16_byte(crc, byte_data);
                        idx_d = idx + 2'd1;
                        if (idx == 2'd1) begin
                            ns         = HUNT;
                            ev_id_done = 1'b1;
                        end
                    end
                    DATA: begin
                        crc_d   = crc16_byte(crc, byte_data);
                        ev_data = 1'b1;
                        if (data_rem == 11'd0) begin
                            ns    = DATA_CRC;
                            idx_d = 2'd0;
                        end
                    end
                    DATA_CRC: begin
                        crc_d = crc16_byte(crc, byte_data);
                        idx_d = idx + 2'd1;
                        if (idx == 2'd1) begin
                            ns           = HUNT;
                            ev_data_done = 1'b1;
                        end
                    end
                    default: ns = HUNT;
                endcase
            end
        end
    end

    // ---- byte stage -> registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            crc          <= CRC_INIT;
            a_cnt        <= 2'd0;
            idx          <= 2'd0;
            data_rem     <= 11'd0;
            win_cnt      <= '0;
            id_open      <= 1'b0;
            id_valid     <= 1'b0;
            id_cyl       <= 8'd0;
            id_head      <= 8'd0;
            id_sector    <= 8'd0;
            id_size      <= 8'd0;
            id_crc_ok    <= 1'b0;
            size_error   <= 1'b0;
            data_valid   <= 1'b0;
            data_byte    <= 8'd0;
            data_last    <= 1'b0;
            data_deleted <= 1'b0;
            data_done    <= 1'b0;
            data_crc_ok  <= 1'b0;
            orphan_dam   <= 1'b0;
        end else begin
            crc        <= crc_d;
            a_cnt      <= a_cnt_d;
            idx        <= idx_d;
            id_valid   <= 1'b0;
            size_error <= 1'b0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            data_done  <= 1'b0;
            orphan_dam <= ev_orphan;

            if (!abort && byte_valid && !sync_mark && state == ID) begin
                case (idx)
                    2'd0:    id_cyl    <= byte_data;
                    2'd1:    id_head   <= byte_data;
                    2'd2:    id_sector <= byte_data;
                    default: id_size   <= byte_data;
                endcase
            end

            if (ev_id_done) begin
                id_valid   <= 1'b1;
                id_crc_ok  <= (crc_d == 16'h0000);
                size_error <= (id_size > 8'(MAX_SIZE_CODE));
            end

            // Window of bytes after a good ID during which a data mark is accepted.
            if (abort || ev_fe || ev_dam) begin
                id_open <= 1'b0;
                win_cnt <= '0;
            end else if (ev_id_done) begin
                if (crc_d == 16'h0000 && id_size <= 8'(MAX_SIZE_CODE)) begin
                    id_open <= 1'b1;
                    win_cnt <= WIN_W'(DAM_WINDOW);
                end
            end else if (byte_valid && id_open && (state == HUNT || state == SYNC)) begin
                if (win_cnt <= WIN_W'(1)) begin
                    id_open <= 1'b0;
                    win_cnt <= '0;
                end else begin
                    win_cnt <= win_cnt - WIN_W'(1);
                end
            end

            // Remaining-byte counter is loaded with length-1 so zero marks the last byte.
            if (ev_dam) begin
                data_rem <= (11'd128 << id_size[1:0]) - 11'd1;
            end else if (ev_data) begin
                data_rem <= data_rem - 11'd1;
            end

            if (ev_data) begin
                data_valid <= 1'b1;
                data_byte  <= byte_data;
                data_last  <= (data_rem == 11'd0);
            end

            // Deleted flag stays up through the data_done cycle, then drops.
            if (ev_dam) begin
                data_deleted <= (byte_data == MARK_DEL);
            end else if (ev_drop || data_done) begin
                data_deleted <= 1'b0;
            end

            if (ev_data_done) begin
                data_done   <= 1'b1;
                data_crc_ok <= (crc_d == 16'h0000);
            end
        end
    end

endmodule

// File: tb/tb_mfm_field_decoder.sv
module tb_mfm_field_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       byte_valid, sync_mark, abort;
    logic [7:0] byte_data;
    logic       id_valid, id_crc_ok, data_valid, data_last, data_deleted;
    logic       data_done, data_crc_ok, size_error, orphan_dam, busy;
    logic [7:0] id_cyl, id_head, id_sector, id_size, data_byte;

    mfm_field_decoder #(.MAX_SIZE_CODE(3), .DAM_WINDOW(43)) dut (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .sync_mark(sync_mark), .abort(abort), .id_valid(id_valid),
        .id_cyl(id_cyl), .id_head(id_head), .id_sector(id_sector), .id_size(id_size),
        .id_crc_ok(id_crc_ok), .data_valid(data_valid), .data_byte(data_byte),
        .data_last(data_last), .data_deleted(data_deleted), .data_done(data_done),
        .data_crc_ok(data_crc_ok), .size_error(size_error), .orphan_dam(orphan_dam),
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam int K_ID = 0, K_DATA = 1, K_DONE = 2, K_ORPHAN = 3;
    typedef struct {
        int         kind;
        logic [7:0] a, b, c, d;
        logic       f1, f2;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] tcrc;
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic exp_t mk(input int kind, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d,
                                input logic f1, input logic f2);
        exp_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.d = d; e.f1 = f1; e.f2 = f2;
        return e;
    endfunction

    // Scoreboard monitor: pops one expectation per presented event.
    task automatic expect_event(input int kind, input string name, output exp_t e, output bit ok);
        ok = 1'b0;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected event, kind %0d observed, none expected", name, kind);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                fails++;
                $display("FAIL %s: event kind %0d observed, expected kind %0d", name, kind, e.kind);
            end else ok = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (mon_en) begin
            if (size_error && !id_valid) check("size_error_alone", 32'(size_error), 32'd0);
            if (id_valid) begin
                expect_event(K_ID, "id_event", e, ok);
                if (ok) begin
                    check("id_cyl", 32'(id_cyl), 32'(e.a));
                    check("id_head", 32'(id_head), 32'(e.b));
                    check("id_sector", 32'(id_sector), 32'(e.c));
                    check("id_size", 32'(id_size), 32'(e.d));
                    check("id_crc_ok", 32'(id_crc_ok), 32'(e.f1));
                    check("size_error", 32'(size_error), 32'(e.f2));
                end
            end
            if (data_valid) begin
                expect_event(K_DATA, "data_event", e, ok);
                if (ok) begin
                    check("data_byte", 32'(data_byte), 32'(e.a));
                    check("data_last", 32'(data_last), 32'(e.f1));
                    check("data_deleted", 32'(data_deleted), 32'(e.f2));
                end
            end
            if (data_done) begin
                expect_event(K_DONE, "done_event", e, ok);
                if (ok) check("data_crc_ok", 32'(data_crc_ok), 32'(e.f1));
            end
            if (orphan_dam) expect_event(K_ORPHAN, "orphan_event", e, ok);
        end
    end

    task automatic put(input logic [7:0] b, input logic s);
        @(negedge clk);
        byte_valid = 1'b1; byte_data = b; sync_mark = s;
        @(negedge clk);
        byte_valid = 1'b0; sync_mark = 1'b0;
        tcrc = crc_ref(tcrc, b);
    endtask

    task automatic sync3();
        tcrc = 16'hFFFF;
        repeat (3) put(8'hA1, 1'b1);
    endtask

    task automatic send_id(input logic [7:0] c, input logic [7:0] h, input logic [7:0] r,
                           input logic [7:0] n, input logic bad);
        logic [15:0] fcs;
        sync3();
        put(8'hFE, 1'b0);
        put(c, 1'b0); put(h, 1'b0); put(r, 1'b0); put(n, 1'b0);
        fcs = tcrc;
        q.push_back(mk(K_ID, c, h, r, n, !bad, (n > 8'd3)));
        put(fcs[15:8], 1'b0);
        put(fcs[7:0] ^ {7'd0, bad}, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) put(8'h4E, 1'b0);
    endtask

    // Data mark plus nbytes of payload; CRC bytes only when full is set.
    task automatic send_data(input logic [7:0] mark, input int nbytes, input int total, input logic full);
        logic [15:0] fcs;
        logic [7:0]  v;
        sync3();
        put(mark, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            v = 8'(i) ^ 8'h5A;
            q.push_back(mk(K_DATA, v, 8'd0, 8'd0, 8'd0, (i == total - 1), (mark == 8'hF8)));
            put(v, 1'b0);
        end
        if (full) begin
            fcs = tcrc;
            q.push_back(mk(K_DONE, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0));
            put(fcs[15:8], 1'b0);
            put(fcs[7:0], 1'b0);
        end
    endtask

    task automatic orphan_mark();
        sync3();
        q.push_back(mk(K_ORPHAN, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
        put(8'hFB, 1'b0);
    endtask

    initial begin
        reset = 1'b1; byte_valid = 1'b0; sync_mark = 1'b0; abort = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_id_valid", 32'(id_valid), 32'd0);
        check("reset_data_valid", 32'(data_valid), 32'd0);
        check("reset_id_cyl", 32'(id_cyl), 32'd0);
        check("reset_data_byte", 32'(data_byte), 32'd0);
        check("reset_crc", 32'(dut.crc), 32'h0000FFFF);
        mon_en = 1'b1;

        // Bare sync run: register holds CRC of A1 A1 A1, no pulses.
        sync3();
        check("a1x3_crc", 32'(dut.crc), 32'h0000CDB4);
        check("a1x3_busy", 32'(busy), 32'd1);
        put(8'h00, 1'b0);
        check("bad_mark_hunt", 32'(busy), 32'd0);

        // Good ID, then corrupted-CRC ID followed by an orphaned data mark.
        send_id(8'h02, 8'h00, 8'h05, 8'h02, 1'b0);
        send_id(8'h02, 8'h00, 8'h05, 8'h02, 1'b1);
        orphan_mark();

        // Deleted data field of 512 bytes within the window.
        send_id(8'h02, 8'h00, 8'h05, 8'h02, 1'b0);
        gap(22);
        send_data(8'hF8, 512, 512, 1'b1);
        put(8'h4E, 1'b0);
        check("deleted_cleared", 32'(data_deleted), 32'd0);

        // Window expiry.
        send_id(8'h02, 8'h00, 8'h06, 8'h02, 1'b0);
        gap(44);
        orphan_mark();

        // Oversized N: size_error and no accepted ID.
        send_id(8'h01, 8'h01, 8'h01, 8'h04, 1'b0);
        orphan_mark();

        // Abort at data byte 100, abort given priority over a coincident byte.
        send_id(8'h03, 8'h01, 8'h07, 8'h01, 1'b0);
        send_data(8'hFB, 100, 256, 1'b0);
        @(negedge clk);
        abort = 1'b1; byte_valid = 1'b1; byte_data = 8'h77;
        @(negedge clk);
        abort = 1'b0; byte_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        gap(4);
        orphan_mark();

        // Resync at data byte 50.
        send_id(8'h04, 8'h00, 8'h01, 8'h00, 1'b0);
        send_data(8'hFB, 50, 128, 1'b0);
        put(8'hA1, 1'b1);
        check("resync_busy", 32'(busy), 32'd1);
        put(8'h00, 1'b0);
        check("resync_hunt", 32'(busy), 32'd0);
        gap(6);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
